idct_row_gather: RTL and testbench

Serial-to-parallel row assembler for the second 1-D IDCT pass. It sits directly downstream of the transpose memory controller. It takes the transposed coefficient stream, one sample per cycle, with its 2-bit transform-size tag, and packs consecutive samples into 4- or 8-lane row vectors. Each completed row is issued to the second-pass butterfly with a single-cycle valid strobe plus row index and end-of-block flags.

---
 rtl/idct_row_gather.sv | 207 ++++++++++++++++++++
 tb/tb_idct_row_gather.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/idct_row_gather.sv
// ----------------------------------------------------------------------------
// idct_row_gather
//
// Serial-to-parallel row assembler feeding the second 1-D IDCT pass. Takes the
// transposed coefficient stream (one sample per cycle, tagged with a 2-bit
// transform size) and packs consecutive samples into 4-lane (4x4 mode) or
// 8-lane (8x8 mode) row vectors. A group is always 64 samples. Each finished
// row is issued with a one-cycle strobe plus its row index and an
// end-of-group flag.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     d_in / idct_mode carry a sample this cycle
//   idct_mode    01 = 4x4, 10 = 8x8, 00 = idle (abandon group), 11 = illegal
//   d_in         transposed coefficient, passed through bit-exact
//   out_valid    one-cycle strobe, out_row holds a completed row
//   out_mode     mode of the group the row belongs to
//   out_row      lane k at [k*WIDTH_X +: WIDTH_X], first sample in lane 0
//   out_row_idx  row number within the group (0-15 in 4x4, 0-7 in 8x8)
//   out_last     row contains sample 63 of the group
//   err          one-cycle pulse on a mode change mid-group or illegal mode
// ----------------------------------------------------------------------------
module idct_row_gather #(
  parameter int WIDTH_X = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [1:0]           idct_mode,
  input  logic [WIDTH_X-1:0]   d_in,
  output logic                 out_valid,
  output logic [1:0]           out_mode,
  output logic [8*WIDTH_X-1:0] out_row,
  output logic [3:0]           out_row_idx,
  output logic                 out_last,
  output logic                 err
);

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_4X4  = 2'b01;
  localparam logic [1:0] MODE_8X8  = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  typedef logic [7:0][WIDTH_X-1:0] row_t;

  // Control state
  state_t     state_q, state_d;
  logic [5:0] scnt_q, scnt_d;
  logic [1:0] mode_q, mode_d;

  // Row buffer and registered outputs
  row_t       row_q;
  row_t       row_next;
  row_t       out_row_q;
  row_t       out_row_d;
  logic [1:0] out_mode_q;
  logic [3:0] out_row_idx_q;
  logic [3:0] row_idx_d;
  logic       out_last_q;
  logic       out_valid_q;
  logic       err_q;

  // Per-sample decode
  logic       accept;     // sample is written into the row buffer
  logic       err_d;
  logic [5:0] idx;        // position of the accepted sample within the group
  logic       is_4x4;
  logic [2:0] lane;
  logic       row_done;

  // --------------------------------------------------------------------------
  // Next-state / control decode
  // --------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, otherwise a path that
  // skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    mode_d  = mode_q;
    accept  = 1'b0;
    err_d   = 1'b0;
    idx     = scnt_q;

    if (in_valid) begin
      case (idct_mode)
        MODE_ILL: begin
          // Sample is dropped and any group in progress is abandoned.
          err_d   = 1'b1;
          state_d = IDLE;
          scnt_d  = '0;
          mode_d  = MODE_IDLE;
        end
        MODE_IDLE: begin
          // Graceful abort: partial row discarded, no error.
          state_d = IDLE;
          scnt_d  = '0;
          mode_d  = MODE_IDLE;
        end
        default: begin
          accept = 1'b1;
          mode_d = idct_mode;
          if (state_q == IDLE) begin
            idx = '0;
          end else if (idct_mode != mode_q) begin
            // Restart: this sample becomes sample 0 of a new group.
            idx   = '0;
            err_d = 1'b1;
          end
          if (idx == 6'd63) begin
            state_d = IDLE;
            scnt_d  = '0;
            mode_d  = MODE_IDLE;
          end else begin
            state_d = FILL;
            scnt_d  = idx + 6'd1;
          end
        end
      endcase
    end
  end

  // Lane / row bookkeeping for the sample being accepted. The mode used is
  // the one carried with the sample, which is also the mode being latched.
  assign is_4x4   = (idct_mode == MODE_4X4);
  assign lane     = is_4x4 ? {1'b0, idx[1:0]} : idx[2:0];
  assign row_done = accept && (is_4x4 ? (idx[1:0] == 2'd3) : (idx[2:0] == 3'd7));

  // --------------------------------------------------------------------------
  // Row buffer update and completed-row image
  // --------------------------------------------------------------------------
  always_comb begin
    // Writing lane 0 starts a fresh row: clear everything else so nothing
    // from an earlier (possibly 8-lane) row survives.
    row_next = (lane == 3'd0) ? '0 : row_q;
    row_next[lane] = d_in;

    out_row_d = row_next;
    if (is_4x4) begin
      out_row_d[7:4] = '0;
    end

    row_idx_d = is_4x4 ? idx[5:2] : {1'b0, idx[5:3]};
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      mode_q  <= MODE_IDLE;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      mode_q  <= mode_d;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  // NOTE: the row buffer is reset along with the outputs; it is only eight
  // flops wide per bit, and a reset mid-row must leave no partial data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q         <= '0;
      out_row_q     <= '0;
      out_mode_q    <= MODE_IDLE;
      out_row_idx_q <= '0;
      out_last_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      out_valid_q <= row_done;
      err_q       <= err_d;

      if (accept) begin
        row_q <= row_next;
      end

      // Output register holds until the next completed row.
      if (row_done) begin
        out_row_q     <= out_row_d;
        out_mode_q    <= idct_mode;
        out_row_idx_q <= row_idx_d;
        out_last_q    <= (idx == 6'd63);
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_mode    = out_mode_q;
  assign out_row     = out_row_q;
  assign out_row_idx = out_row_idx_q;
  assign out_last    = out_last_q;
  assign err         = err_q;

endmodule

// File: tb/tb_idct_row_gather.sv
// ----------------------------------------------------------------------------
// tb_idct_row_gather
//
// Directed self-checking bench for idct_row_gather. Inputs change on the
// falling edge; outputs are sampled on the following falling edge, after the
// rising edge that consumed the inputs. Expected rows are built from the
// sample values the bench itself sent.
// ----------------------------------------------------------------------------
module tb_idct_row_gather;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [1:0]     idct_mode;
  logic [W-1:0]   d_in;
  logic           out_valid;
  logic [1:0]     out_mode;
  logic [8*W-1:0] out_row;
  logic [3:0]     out_row_idx;
  logic           out_last;
  logic           err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]   vals [64];
  logic [8*W-1:0] exp_row;
  logic [8*W-1:0] held_row;

  idct_row_gather #(.WIDTH_X(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .idct_mode   (idct_mode),
    .d_in        (d_in),
    .out_valid   (out_valid),
    .out_mode    (out_mode),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_last    (out_last),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present one input cycle; returns at the next falling edge, when the
  // outputs reflect that cycle.
  task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] d);
    in_valid  = v;
    idct_mode = m;
    d_in      = d;
    @(negedge clk);
  endtask

  // Send vals[0..count-1] as a group starting at row 0 and check every cycle.
  task automatic send_seq(input logic [1:0] m, input int count, input string tag);
    int len;
    len = (m == 2'b01) ? 4 : 8;
    for (int n = 0; n < count; n++) begin
      drive(1'b1, m, vals[n]);
      check($sformatf("%s valid n=%0d", tag, n), 128'(out_valid), 128'((n + 1) % len == 0));
      check($sformatf("%s err n=%0d", tag, n), 128'(err), 128'(0));
      if ((n + 1) % len == 0) begin
        exp_row = '0;
        for (int k = 0; k < len; k++) exp_row[k*W +: W] = vals[n - len + 1 + k];
        check($sformatf("%s row n=%0d", tag, n), out_row, exp_row);
        check($sformatf("%s idx n=%0d", tag, n), 128'(out_row_idx), 128'(n / len));
        check($sformatf("%s last n=%0d", tag, n), 128'(out_last), 128'(n == 63));
        check($sformatf("%s mode n=%0d", tag, n), 128'(out_mode), 128'(m));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valid"}, 128'(out_valid), 128'(0));
    check({tag, " row"},   out_row, 128'(0));
    check({tag, " idx"},   128'(out_row_idx), 128'(0));
    check({tag, " mode"},  128'(out_mode), 128'(0));
    check({tag, " last"},  128'(out_last), 128'(0));
    check({tag, " err"},   128'(err), 128'(0));
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    idct_mode = 2'b00;
    d_in      = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // 8x8 stream: samples 0..63
    for (int n = 0; n < 64; n++) vals[n] = W'(n);
    send_seq(2'b10, 64, "s8x8");
    drive(1'b0, 2'b00, '0);
    check("s8x8 single strobe", 128'(out_valid), 128'(0));

    // 4x4 stream: samples 0x100+n
    for (int n = 0; n < 64; n++) vals[n] = W'(16'h100 + n);
    send_seq(2'b01, 64, "s4x4");

    // Stalls after samples 2 and 5: strobe lands 14 cycles after sample 0
    cyc = 0;
    for (int n = 0; n < 8; n++) begin
      drive(1'b1, 2'b10, W'(n));
      cyc++;
      if (n == 2 || n == 5) begin
        for (int s = 0; s < 3; s++) begin
          drive(1'b0, 2'b10, 16'hDEAD);
          cyc++;
          check($sformatf("stall valid n=%0d s=%0d", n, s), 128'(out_valid), 128'(0));
        end
      end else if (n != 7) begin
        check($sformatf("stall valid n=%0d", n), 128'(out_valid), 128'(0));
      end
    end
    check("stall strobe", 128'(out_valid), 128'(1));
    check("stall latency", 128'(cyc), 128'(14));
    check("stall row", out_row, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    check("stall idx", 128'(out_row_idx), 128'(0));

    // Mode 00 mid-group: no error, next group restarts at row 0
    drive(1'b1, 2'b00, 16'h1234);
    check("idle err", 128'(err), 128'(0));
    check("idle valid", 128'(out_valid), 128'(0));
    for (int n = 0; n < 8; n++) vals[n] = W'(16'h0A00 + n);
    send_seq(2'b10, 8, "after idle");

    // Mode change mid-row: three 8x8 samples then a 4x4 sample
    drive(1'b1, 2'b00, '0);
    drive(1'b1, 2'b10, 16'hA000);
    drive(1'b1, 2'b10, 16'hA001);
    drive(1'b1, 2'b10, 16'hA002);
    check("mchg err before", 128'(err), 128'(0));
    drive(1'b1, 2'b01, 16'hB000);
    check("mchg err pulse", 128'(err), 128'(1));
    check("mchg no strobe", 128'(out_valid), 128'(0));
    drive(1'b1, 2'b01, 16'hB001);
    check("mchg err once", 128'(err), 128'(0));
    drive(1'b1, 2'b01, 16'hB002);
    check("mchg no strobe 2", 128'(out_valid), 128'(0));
    drive(1'b1, 2'b01, 16'hB003);
    check("mchg strobe", 128'(out_valid), 128'(1));
    check("mchg mode", 128'(out_mode), 128'(2'b01));
    check("mchg idx", 128'(out_row_idx), 128'(0));
    check("mchg row", out_row, 128'h0000_0000_0000_0000_B003_B002_B001_B000);
    check("mchg err low", 128'(err), 128'(0));
    held_row = 128'h0000_0000_0000_0000_B003_B002_B001_B000;

    // Illegal mode mid-row: sample dropped, err pulses, output held
    drive(1'b1, 2'b01, 16'hB004);
    drive(1'b1, 2'b01, 16'hB005);
    drive(1'b1, 2'b11, 16'hEEEE);
    check("ill err", 128'(err), 128'(1));
    check("ill no strobe", 128'(out_valid), 128'(0));
    check("ill row held", out_row, held_row);
    drive(1'b0, 2'b00, '0);
    check("ill err once", 128'(err), 128'(0));
    for (int n = 0; n < 8; n++) vals[n] = W'(16'hD000 + n);
    send_seq(2'b10, 8, "after ill");

    // Asynchronous reset mid-row
    drive(1'b1, 2'b00, '0);
    for (int n = 0; n < 5; n++) drive(1'b1, 2'b10, W'(16'hE000 + n));
    check("pre-reset row", out_row, 128'hD007_D006_D005_D004_D003_D002_D001_D000);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) vals[n] = W'(16'hF000 + n);
    send_seq(2'b10, 8, "after reset");

    // Two groups back to back with negative values
    drive(1'b1, 2'b00, '0);
    for (int n = 0; n < 64; n++) vals[n] = n[0] ? W'(16'hFFFF - n) : W'(16'h8000 + n);
    vals[0] = 16'h8000;
    vals[1] = 16'hFFFF;
    send_seq(2'b10, 64, "sign g1");
    for (int n = 0; n < 64; n++) vals[n] = n[0] ? 16'h8000 : 16'hFFFF;
    send_seq(2'b10, 64, "sign g2");
    drive(1'b0, 2'b00, '0);
    check("sign end valid", 128'(out_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
